// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame width and mode-0 edge constants.
package spi_pkg;
  localparam int DEFAULT_DATA_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Mode 0: sclk idles low, data sampled on the rising edge and launched on the falling edge.
  localparam logic CPOL    = 1'b0;
  localparam logic SS_IDLE = 1'b1;
endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-clk rise/fall pulses.
module spi_sync import spi_pkg::*; #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = CPOL
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, MSB first, oversampled by clk. Define SPI_SLAVE_UNDERRUN_EN to add the
// tx_underrun pulse output.
module spi_slave import spi_pkg::*; #(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic              tx_underrun
`endif
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_unused_lvl, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_unused_rise, mosi_unused_fall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(sclk), .q_o(sclk_unused_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SS_IDLE)) u_sync_ss (
    .clk(clk), .reset(reset), .d_i(ss), .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(mosi), .q_o(mosi_s), .rise_o(mosi_unused_rise), .fall_o(mosi_unused_fall));

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]      hold_q, hold_d, rx_data_q, rx_data_d;
  logic                   hold_full_q, hold_full_d, rx_valid_q, rx_valid_d, miso_q, miso_d;
  logic                   armed_q, armed_d;
  logic [SYNC_STAGES-1:0] settle_q, settle_d;
  logic                   sample_edge, shift_edge;
  logic [DATA_W-1:0]      rx_next;

  assign sample_edge = CPOL ? sclk_fall : sclk_rise;
  assign shift_edge  = CPOL ? sclk_rise : sclk_fall;
  assign rx_next     = {rx_sh_q[DATA_W-2:0], mosi_s};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    // A frame already in progress at reset release is ignored: arm only once ss is seen high.
    settle_d    = {settle_q[SYNC_STAGES-2:0], 1'b1};
    armed_d     = armed_q | (settle_q[SYNC_STAGES-1] & ss_s);
    case (state_q)
      ST_IDLE: begin
        miso_d  = 1'b0;
        cnt_d   = '0;
        rx_sh_d = '0;
        if (ss_fall && armed_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tx_sh_d     = hold_full_q ? hold_q : '0;
        miso_d      = hold_full_q & hold_q[DATA_W-1];
        hold_full_d = 1'b0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sample_edge) begin
          rx_sh_d = rx_next;
          if (cnt_q == LAST_BIT) begin
            cnt_d      = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            state_d    = ST_LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // The fall trailing the last bit of a byte (counter back at 0) must not disturb the MSB LOAD placed.
        if (shift_edge && cnt_q != '0) begin
          tx_sh_d = tx_sh_q << 1;
          miso_d  = tx_sh_q[DATA_W-2];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ss_rise) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      rx_sh_d     = '0;
      miso_d      = 1'b0;
      tx_sh_d     = tx_sh_q;
      hold_full_d = hold_full_q;
    end
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      armed_q     <= 1'b0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      armed_q     <= armed_d;
      settle_q    <= settle_d;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) underrun_q <= 1'b0;
    else        underrun_q <= (state_q == ST_LOAD) && !hold_full_q && !ss_rise;
  end
  assign tx_underrun = underrun_q;
`endif

  assign miso     = miso_q;
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != ST_IDLE);
endmodule
